heater_err_monitor: RTL and testbench

//  Consumes the per-channel `error` outputs of NUM_CH heater channels.
//  - Keeps a sticky error flag and a saturating error-event counter per channel.
//  - Drives the shared err_clear pulse back into all channels, then masks a

---
 rtl/heater_err_monitor.sv | 109 ++++++++++
 tb/tb_heater_err_monitor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/heater_err_monitor.sv
// rtl/heater_err_monitor.sv - sticky error flags, saturating event counters and
// clear/settle sequencer for an array of heater channels.
module heater_err_monitor #(
  parameter int NUM_CH     = 8,
  parameter int CNT_W      = 16,
  parameter int CLR_CYCLES = 4,
  parameter int SETTLE_CYC = 64,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_error,
  input  logic              clear_req,
  output logic              err_clear,
  output logic              busy,
  output logic [NUM_CH-1:0] err_sticky,
  output logic              any_error,
  input  logic [SEL_W-1:0]  ch_sel,
  output logic [CNT_W-1:0]  err_count
);

  localparam int TMAX = (CLR_CYCLES > SETTLE_CYC) ? CLR_CYCLES : SETTLE_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [TW-1:0]     timer, timer_next;
  logic              start;
  logic              idle;
  logic [NUM_CH-1:0] err_q;
  logic [NUM_CH-1:0] evt;
  logic [CNT_W-1:0]  cnt [NUM_CH];

  assign idle = (state == IDLE);
  // err_q is forced low outside IDLE so a level still high on return counts once
  assign evt  = ch_error & ~err_q & {NUM_CH{idle}};

  always_comb begin
    state_next = state;
    timer_next = timer;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          timer_next = TW'(CLR_CYCLES - 1);
          start      = 1'b1;
        end
      end
      CLEAR: begin
        if (timer == '0) begin
          state_next = SETTLE;
          timer_next = TW'(SETTLE_CYC - 1);
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      SETTLE: begin
        if (timer == '0) state_next = IDLE;
        else             timer_next = timer - TW'(1);
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      err_clear <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      err_clear <= (state_next == CLEAR);
      busy      <= (state_next != IDLE);
    end
  end

  // A clear request wins over a same-cycle event: counter and sticky end at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      err_sticky <= '0;
      err_q      <= '0;
      any_error  <= 1'b0;
      err_count  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (start)                          cnt[i] <= '0;
        else if (evt[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
      if (start)     err_sticky <= '0;
      else if (idle) err_sticky <= err_sticky | ch_error;
      err_q     <= idle ? ch_error : '0;
      any_error <= |err_sticky;
      err_count <= (32'(ch_sel) < NUM_CH) ? cnt[ch_sel] : '0;
    end
  end

endmodule

// File: tb/tb_heater_err_monitor.sv
// tb/tb_heater_err_monitor.sv - randomized and directed bench for heater_err_monitor
// against a remaining-busy-cycles reference model.
module tb_heater_err_monitor;
  localparam int NUM_CH = 8;
  localparam int CNT_W  = 4;
  localparam int CLR    = 4;
  localparam int SET    = 64;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_error;
  logic              clear_req;
  logic              err_clear;
  logic              busy;
  logic [NUM_CH-1:0] err_sticky;
  logic              any_error;
  logic [2:0]        ch_sel;
  logic [CNT_W-1:0]  err_count;

  heater_err_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CLR_CYCLES(CLR), .SETTLE_CYC(SET)
  ) dut (
    .clk(clk), .reset(reset), .ch_error(ch_error), .clear_req(clear_req),
    .err_clear(err_clear), .busy(busy), .err_sticky(err_sticky),
    .any_error(any_error), .ch_sel(ch_sel), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int                busy_left;
  int                m_cnt [NUM_CH];
  logic [NUM_CH-1:0] m_sticky, m_prev;
  logic              m_any, m_clr, m_busy;
  logic [CNT_W-1:0]  m_count;

  task automatic model_zero();
    busy_left = 0;
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    m_sticky = '0; m_prev = '0; m_any = 0; m_clr = 0; m_busy = 0; m_count = '0;
  endtask

  task automatic tick(input logic [NUM_CH-1:0] ce, input logic cr, input logic [2:0] sel);
    logic [NUM_CH-1:0] old_sticky;
    int old_cnt;
    bit idle;
    ch_error = ce; clear_req = cr; ch_sel = sel;
    old_sticky = m_sticky;
    old_cnt    = m_cnt[sel];
    idle       = (busy_left == 0);
    if (idle && cr) begin
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      m_sticky  = '0;
      busy_left = CLR + SET;
    end else if (idle) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ce[i] && !m_prev[i] && m_cnt[i] < CMAX) m_cnt[i]++;
        if (ce[i]) m_sticky[i] = 1'b1;
      end
    end else begin
      busy_left--;
    end
    m_prev  = idle ? ce : '0;
    m_any   = |old_sticky;
    m_count = CNT_W'(old_cnt);
    m_busy  = (busy_left > 0);
    m_clr   = (busy_left > SET);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ch_error = '0; clear_req = 1'b0; ch_sel = '0;
    model_zero();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 100; c++) tick('0, 1'b0, 3'(c));
    checks++;
    if ({err_clear, busy, err_sticky, any_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got clr=%b busy=%b sticky=%h any=%b want all 0",
               err_clear, busy, err_sticky, any_error);
    end
    for (int s = 0; s < NUM_CH; s++) begin
      tick('0, 1'b0, 3'(s));
      tick('0, 1'b0, 3'(s));
      checks++;
      if (err_count !== '0) begin
        errors++;
        $display("FAIL reset_count ch%0d got %0d want 0", s, err_count);
      end
    end
  endtask

  task automatic test_pulse_count();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      tick(8'h08, 1'b0, 3'd3);
      tick('0, 1'b0, 3'd3);
      tick('0, 1'b0, 3'd3);
    end
    checks++;
    if (err_count !== 4'd3 || m_count !== 4'd3) begin
      errors++;
      $display("FAIL pulse_count got %0d model %0d want 3", err_count, m_count);
    end
    checks++;
    if (err_sticky !== 8'h08 || any_error !== 1'b1) begin
      errors++;
      $display("FAIL pulse_sticky got sticky=%h any=%b want 08/1", err_sticky, any_error);
    end
    for (int s = 0; s < NUM_CH; s++) begin
      if (s == 3) continue;
      tick('0, 1'b0, 3'(s));
      tick('0, 1'b0, 3'(s));
      checks++;
      if (err_count !== '0) begin
        errors++;
        $display("FAIL pulse_other ch%0d got %0d want 0", s, err_count);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int c = 0; c < 500; c++)
      tick({6'b0, (c % 20 == 0 && c < 400), 1'b1}, 1'b0, 3'd0);
    tick(8'h01, 1'b0, 3'd0);
    checks++;
    if (err_count !== 4'd1) begin
      errors++;
      $display("FAIL sat_ch0 got %0d want 1", err_count);
    end
    tick(8'h01, 1'b0, 3'd1);
    tick(8'h01, 1'b0, 3'd1);
    checks++;
    if (err_count !== 4'd15 || m_count !== 4'd15) begin
      errors++;
      $display("FAIL sat_ch1 got %0d model %0d want 15", err_count, m_count);
    end
  endtask

  task automatic test_clear();
    int n_clr, n_busy;
    do_reset();
    tick(8'h20, 1'b0, 3'd5);
    tick('0, 1'b0, 3'd5);
    checks++;
    if (err_sticky !== 8'h20) begin
      errors++;
      $display("FAIL clear_presticky got %h want 20", err_sticky);
    end
    tick('0, 1'b1, 3'd5);
    n_clr = 0; n_busy = 0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      n_busy++;
      if (err_clear) n_clr++;
      checks++;
      if (err_sticky !== '0 || err_clear !== m_clr) begin
        errors++;
        $display("FAIL clear_during got sticky=%h clr=%b want 00/%b", err_sticky, err_clear, m_clr);
      end
      tick(8'($urandom), 1'b0, 3'd5);
    end
    checks++;
    if (n_clr !== CLR || n_busy !== CLR + SET) begin
      errors++;
      $display("FAIL clear_len got clr=%0d busy=%0d want %0d/%0d", n_clr, n_busy, CLR, CLR + SET);
    end
    checks++;
    if (err_sticky !== '0) begin
      errors++;
      $display("FAIL clear_after_sticky got %h want 00", err_sticky);
    end
    tick(8'h20, 1'b0, 3'd5);
    checks++;
    if (err_count !== '0) begin
      errors++;
      $display("FAIL clear_after_count got %0d want 0", err_count);
    end
    tick(8'h20, 1'b0, 3'd5);
    checks++;
    if (err_count !== 4'd1 || err_sticky !== 8'h20) begin
      errors++;
      $display("FAIL clear_relevel got cnt=%0d sticky=%h want 1/20", err_count, err_sticky);
    end
  endtask

  task automatic test_clear_collision();
    int n_busy;
    do_reset();
    tick('0, 1'b0, 3'd2);
    tick(8'h04, 1'b1, 3'd2);
    n_busy = 0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      n_busy++;
      tick('0, (c == 10 || c == 30), 3'd2);
    end
    checks++;
    if (n_busy !== CLR + SET) begin
      errors++;
      $display("FAIL collide_busy got %0d want %0d", n_busy, CLR + SET);
    end
    tick('0, 1'b0, 3'd2);
    tick('0, 1'b0, 3'd2);
    checks++;
    if (err_count !== '0 || err_sticky !== '0) begin
      errors++;
      $display("FAIL collide_ch2 got cnt=%0d sticky=%h want 0/00", err_count, err_sticky);
    end
  endtask

  task automatic test_reset_mid();
    int n_clr;
    do_reset();
    tick('0, 1'b1, 3'd0);
    tick('0, 1'b0, 3'd0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (err_clear !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got clr=%b busy=%b want 0/0", err_clear, busy);
    end
    model_zero();
    @(posedge clk); #1;
    reset = 1'b0;
    tick('0, 1'b0, 3'd0);
    tick('0, 1'b1, 3'd0);
    n_clr = 0;
    for (int c = 0; c < 200 && busy; c++) begin
      if (err_clear) n_clr++;
      tick('0, 1'b0, 3'd0);
    end
    checks++;
    if (n_clr !== CLR) begin
      errors++;
      $display("FAIL reset_mid_pulse got %0d want %0d", n_clr, CLR);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick(8'($urandom & $urandom & $urandom), ($urandom_range(0, 59) == 0), 3'($urandom));
      checks++;
      if (err_clear !== m_clr || busy !== m_busy || err_sticky !== m_sticky ||
          any_error !== m_any || err_count !== m_count) begin
        errors++;
        $display("FAIL random c=%0d got clr=%b busy=%b st=%h any=%b cnt=%0d want %b %b %h %b %0d",
                 c, err_clear, busy, err_sticky, any_error, err_count,
                 m_clr, m_busy, m_sticky, m_any, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pulse_count();
    test_saturate();
    test_clear();
    test_clear_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
